lsu_bus_ctrl: RTL
=================

# lsu_bus_ctrl

Load/store bus controller directly downstream of `datapath`. It accepts one data-memory request per execute cycle (`lw`, `lb`, `sw`), using the datapath's data address and store data. It runs a registered request/acknowledge handshake on the external data bus, extracts bytes for `lb`, and returns load data for register-file writeback. It raises `o_busy` so the control unit can stall execute until the access completes or times out.

## Interface
- `TIMEOUT`, default 15: maximum cycles in REQ without `i_bus_ack` before abort; legal range 1..255.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_req`  in  1  request strobe, sampled only in IDLE.
- `i_is_lw`  in  1  word load.
- `i_is_lb`  in  1  byte load, zero-extended.
- `i_is_sw`  in  1  word store.
- `i_ad`  in  16  data byte address (datapath `o_d_ad`).
- `i_wdata`  in  16  store data (datapath `o_data_out`).
- `o_busy`  out  1  access in progress; control unit holds `i_exec_ce` low while set.
- `o_rdata`  out  16  load result (datapath `i_data_in`); valid when `o_rdata_valid`.
- `o_rdata_valid`  out  1  one-cycle pulse per completed or aborted load.
- `o_err`  out  1  one-cycle pulse on timeout abort.
- `o_bus_req`  out  1  bus request, held until ack or timeout.
- `o_bus_we`  out  1  write enable.
- `o_bus_ad`  out  16  word-aligned address, `{i_ad[15:1],1'b0}`.
- `o_bus_be`  out  2  byte enables; bit0 = `[7:0]`, little-endian.
- `o_bus_wdata`  out  16  store data.
- `i_bus_ack`  in  1  slave acknowledge; one cycle.
- `i_bus_rdata`  in  16  read data; valid in the ack cycle.

## Operation
- States: IDLE, REQ, RESP.
- IDLE → REQ when `i_req` is set and at least one op flag is set.
  - Latch op, `o_bus_ad`, `o_bus_be`, `o_bus_we`, `o_bus_wdata`.
  - Clear the timeout counter.
- Flag priority when more than one is set: `sw` > `lw` > `lb`.
- `i_req` with no op flag: ignored; stay in IDLE.
- Byte enables: `lw` and `sw` use `be = 2'b11`. `lb` uses `be = i_ad[0] ? 2'b10 : 2'b01`.
- REQ with `i_bus_ack`:
  - Load: capture data, go to RESP. `lw` captures `i_bus_rdata`. `lb` captures `{8'h00, selected byte}`.
  - Store: go to RESP.
- REQ without ack: the counter increments each cycle. When the counter equals `TIMEOUT - 1`, go to RESP with the error flag set and load data forced to `16'h0000`.
- RESP:
  - Pulse `o_rdata_valid` (loads only).
  - Pulse `o_err` if aborted.
  - Go to IDLE.
- `i_req` while not in IDLE is ignored (no queueing).
- `i_bus_ack` outside REQ is ignored.
- `o_rdata` holds its last value outside RESP.

## Timing
- All outputs are registered or decoded from registered state only.
- Reset values:
  - State IDLE.
  - `o_busy`, `o_bus_req`, `o_bus_we`, `o_rdata_valid`, `o_err` = 0.
  - `o_bus_ad`, `o_bus_wdata`, `o_rdata` = `16'h0000`.
  - `o_bus_be` = `2'b00`.
- `i_rst` mid-access: return to IDLE next edge and drop `o_bus_req` immediately. A later ack must not produce a response.
- Request accepted at edge t:
  - `o_bus_req` and `o_busy` high from t+1.
- Ack sampled at edge k:
  - `o_bus_req` low from k+1.
  - State RESP for the cycle after edge k; `o_rdata_valid` high there.
  - `o_busy` low from edge k+2.
- Minimum access, ack in the first REQ cycle: `o_busy` high for 2 cycles.
- `o_busy` = (state != IDLE).
- Timeout:
  - `o_bus_req` high for exactly `TIMEOUT` cycles.
  - `o_err` pulses in the following cycle.
- Ack in the same cycle the counter reaches `TIMEOUT - 1`: the ack wins, with no error.
- The counter is 8 bits and saturates; it never wraps.

## Structure
- `constants.vh` additions:
  - State encodings `LSU_IDLE`, `LSU_REQ`, `LSU_RESP` (2 bits).
  - `LSU_BE_WORD`, `LSU_BE_LO`, `LSU_BE_HI`.
  - `LSU_TIMEOUT_DEF`.
- Width macros `CPU_N` and `CPU_AN` are reused for data and address.
- One sub-module, `lsu_byte_lane`: combinational byte select and zero-extend for loads, plus byte-enable decode from op and `i_ad[0]`. It is shared with a future `sb`.
- Everything else is in a single module.

## Test plan
- `lw` at `i_ad = 16'h0104`, slave acks 3 cycles after `o_bus_req`:
  - `o_bus_ad = 16'h0104`, `be = 11`, `we = 0`.
  - `o_rdata_valid` one cycle with `o_rdata` = `i_bus_rdata` (`16'hBEEF`).
  - `o_busy` high 5 cycles.
- `lb` at `16'h0201`, `i_bus_rdata = 16'hA55A`, immediate ack:
  - `o_bus_ad = 16'h0200`, `be = 10`.
  - `o_rdata = 16'h00A5`.
  - `o_busy` high exactly 2 cycles.
- `sw` at `16'h0010` with `16'h1234`:
  - `we = 1`, `be = 11`, `wdata = 16'h1234`.
  - No `o_rdata_valid`.
  - `o_busy` falls 2 cycles after ack.
- No ack, `TIMEOUT = 4`:
  - `o_bus_req` high 4 cycles.
  - Then `o_err`, `o_rdata_valid` and `o_rdata = 16'h0000` together for one cycle.
  - Then IDLE.
- Second `i_req` while busy, and `i_req` with all flags set:
  - The busy-cycle request is ignored.
  - With all flags set the store is performed (`we = 1`).
- `i_rst` asserted during REQ, ack arrives next cycle:
  - `o_bus_req` low after the reset edge.
  - No `o_rdata_valid` or `o_err`; state IDLE.

Source files
------------

// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared types and constants for the load/store bus controller.
// State encodings, byte-enable patterns and the op decode live here.
package lsu_bus_ctrl_pkg;

  localparam int CPU_N  = 16;
  localparam int CPU_AN = 16;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_LW   = 2'd1,
    OP_LB   = 2'd2,
    OP_SW   = 2'd3
  } lsu_op_t;

  localparam logic [1:0] LSU_BE_WORD = 2'b11;
  localparam logic [1:0] LSU_BE_LO   = 2'b01;
  localparam logic [1:0] LSU_BE_HI   = 2'b10;

  localparam int LSU_TIMEOUT_DEF = 15;

  // Store beats word load beats byte load when several flags are raised.
  function automatic lsu_op_t lsu_decode_op(input logic is_sw, input logic is_lw,
                                            input logic is_lb);
    lsu_op_t op;
    op = OP_NONE;
    if (is_sw)      op = OP_SW;
    else if (is_lw) op = OP_LW;
    else if (is_lb) op = OP_LB;
    return op;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper: byte-enable decode for an access and load-data
// extraction (byte select plus zero-extend) for the returned bus word.
module lsu_byte_lane
  import lsu_bus_ctrl_pkg::*;
(
  input  lsu_op_t           op,
  input  logic              ad_lsb,
  input  logic [CPU_N-1:0]  bus_rdata,
  output logic [1:0]        be,
  output logic [CPU_N-1:0]  load_data
);

  always_comb begin
    be        = 2'b00;
    load_data = '0;
    unique case (op)
      OP_LW: begin
        be        = LSU_BE_WORD;
        load_data = bus_rdata;
      end
      OP_SW: begin
        be = LSU_BE_WORD;
      end
      OP_LB: begin
        be        = ad_lsb ? LSU_BE_HI : LSU_BE_LO;
        load_data = {8'h00, (ad_lsb ? bus_rdata[15:8] : bus_rdata[7:0])};
      end
      default: begin
        be        = 2'b00;
        load_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: one request/acknowledge data-bus access per
// accepted request, with timeout abort and a busy stall for the control unit.
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_is_lw,
  input  logic              i_is_lb,
  input  logic              i_is_sw,
  input  logic [CPU_AN-1:0] i_ad,
  input  logic [CPU_N-1:0]  i_wdata,
  output logic              o_busy,
  output logic [CPU_N-1:0]  o_rdata,
  output logic              o_rdata_valid,
  output logic              o_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [CPU_AN-1:0] o_bus_ad,
  output logic [1:0]        o_bus_be,
  output logic [CPU_N-1:0]  o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [CPU_N-1:0]  i_bus_rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  lsu_state_t state_q, state_d;
  lsu_op_t    op_q, req_op, lane_op;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       ad_lsb_q, lane_lsb;
  logic       accept, capture;
  logic       op_is_load;
  logic [1:0]       lane_be;
  logic [CPU_N-1:0] lane_data;

  assign req_op     = lsu_decode_op(i_is_sw, i_is_lw, i_is_lb);
  assign op_is_load = (op_q == OP_LW) || (op_q == OP_LB);

  // In IDLE the lane decodes the incoming request; afterwards the latched one.
  assign lane_op  = (state_q == LSU_IDLE) ? req_op : op_q;
  assign lane_lsb = (state_q == LSU_IDLE) ? i_ad[0] : ad_lsb_q;

  lsu_byte_lane u_lane (
    .op        (lane_op),
    .ad_lsb    (lane_lsb),
    .bus_rdata (i_bus_rdata),
    .be        (lane_be),
    .load_data (lane_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      LSU_IDLE: begin
        if (i_req && (req_op != OP_NONE)) begin
          state_d = LSU_REQ;
          accept  = 1'b1;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end
      end
      LSU_REQ: begin
        // An ack in the final counted cycle still completes without error.
        if (i_bus_ack) begin
          state_d = LSU_RESP;
          capture = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          state_d = LSU_RESP;
          err_d   = 1'b1;
          capture = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LSU_RESP: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= LSU_IDLE;
      op_q        <= OP_NONE;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      ad_lsb_q    <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_ad    <= '0;
      o_bus_be    <= 2'b00;
      o_bus_wdata <= '0;
      o_rdata     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        op_q        <= req_op;
        ad_lsb_q    <= i_ad[0];
        o_bus_we    <= (req_op == OP_SW);
        o_bus_ad    <= {i_ad[CPU_AN-1:1], 1'b0};
        o_bus_be    <= lane_be;
        o_bus_wdata <= i_wdata;
      end
      if (capture && op_is_load) begin
        o_rdata <= i_bus_ack ? lane_data : '0;
      end
    end
  end

  assign o_busy        = (state_q != LSU_IDLE);
  assign o_bus_req     = (state_q == LSU_REQ);
  assign o_rdata_valid = (state_q == LSU_RESP) && op_is_load;
  assign o_err         = (state_q == LSU_RESP) && err_q;

endmodule
